// File: rtl/pe_arb_pkg.sv
// Shared types and constants for the four-requester arbiter.
// Holds the FSM state enum, grant vector type and a one-hot helper.
package pe_arb_pkg;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    typedef logic [N_REQ-1:0] gnt_vec_t;

    function automatic gnt_vec_t id_to_onehot(
        input logic [ID_W-1:0] id
    );
        return gnt_vec_t'(1) << id;
    endfunction

endpackage

// File: rtl/pe_prio_enc4.sv
// Combinational 4-to-2 priority encoder, highest set index wins.
// Ports: din[3:0] request bits, idx[1:0] winner index, valid = |din.
module pe_prio_enc4
    import pe_arb_pkg::*;
(
    input  logic [N_REQ-1:0] din,
    output logic [ID_W-1:0]  idx,
    output logic             valid
);

    always_comb begin
        idx   = '0;
        valid = |din;
        priority case (1'b1)
            din[3]:  idx = 2'd3;
            din[2]:  idx = 2'd2;
            din[1]:  idx = 2'd1;
            din[0]:  idx = 2'd0;
            default: idx = 2'd0;
        endcase
    end

endmodule

// File: rtl/pe_arbiter_4.sv
// Four-requester arbiter: fixed priority or round-robin, whole-transaction
// hold, one dead (GAP) cycle between owners.
// Ports: clk, rst_n (async, active-low), req[3:0], done, rr_mode,
//        gnt[3:0] one-hot, gnt_id[1:0], gnt_valid, timeout pulse.
// Optional forced release after HOLD_MAX grant cycles: define
// PE_ARB_TIMEOUT_EN. Without it, timeout is tied low and no counter exists.
module pe_arbiter_4
    import pe_arb_pkg::*;
#(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    input  logic             rr_mode,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam bit CFG_OK = (HOLD_MAX >= 1) && (HOLD_MAX <= 255)
                         && ((2 ** CNT_W) > HOLD_MAX);

    generate
        if (!CFG_OK) begin : g_cfg_err
            $error("pe_arbiter_4: HOLD_MAX/CNT_W out of range");
        end
    endgenerate

    arb_state_t       state;
    arb_state_t       nxt;
    logic [ID_W-1:0]  ptr;
    logic [N_REQ-1:0] rr_rev;
    logic [N_REQ-1:0] enc_in;
    logic [ID_W-1:0]  enc_idx;
    logic             enc_vld;
    logic [ID_W-1:0]  win_id;
    logic             own_req;
    logic             hold_hit;
    logic             rel;
    logic [N_REQ-1:0] gnt_d;
    logic [ID_W-1:0]  id_d;
    logic             valid_d;

    // Round-robin: position 3 of the encoder input carries req[ptr],
    // position 0 carries req[ptr+3], so "highest index wins" becomes
    // "first set bit from ptr upward".
    always_comb begin
        logic [ID_W-1:0] src;
        rr_rev = '0;
        src    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            src = ptr + ID_W'(i);
            rr_rev[N_REQ-1-i] = req[src];
        end
    end

    assign enc_in = rr_mode ? rr_rev : req;

    pe_prio_enc4 u_enc (
        .din   (enc_in),
        .idx   (enc_idx),
        .valid (enc_vld)
    );

    // Encoder index h maps to search offset 3-h, i.e. ~h.
    assign win_id  = rr_mode ? (ptr + ~enc_idx) : enc_idx;
    assign own_req = req[gnt_id];
    assign rel     = (state == GRANT) && (done || !own_req || hold_hit);

`ifdef PE_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] hold_cnt;
    logic             timeout_q;

    // Cleared on the IDLE->GRANT edge; saturates instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (state == IDLE && enc_vld) begin
            hold_cnt <= '0;
        end else if (state == GRANT && hold_cnt != '1) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    assign hold_hit = (state == GRANT)
                   && (hold_cnt == CNT_W'(HOLD_MAX - 1));

    // Only a release caused solely by the hold limit counts as forced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= rel && hold_hit && !done && own_req;
        end
    end

    assign timeout = timeout_q;
`else
    assign hold_hit = 1'b0;
    assign timeout  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (enc_vld) nxt = GRANT;
            GRANT:   if (rel) nxt = GAP;
            GAP:     nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Next values of the registered grant outputs.
    always_comb begin
        gnt_d   = gnt;
        id_d    = gnt_id;
        valid_d = gnt_valid;
        unique case (state)
            IDLE: begin
                if (enc_vld) begin
                    gnt_d   = id_to_onehot(win_id);
                    id_d    = win_id;
                    valid_d = 1'b1;
                end
            end
            GRANT: begin
                if (rel) begin
                    gnt_d   = '0;
                    valid_d = 1'b0;
                end
            end
            default: begin
                gnt_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
        end else begin
            gnt       <= gnt_d;
            gnt_id    <= id_d;
            gnt_valid <= valid_d;
        end
    end

    // Pointer moves past the releasing owner in both modes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (rel) begin
            ptr <= gnt_id + 1'b1;
        end
    end

endmodule

// File: tb/tb_pe_arbiter_4.sv
// Self-checking bench for pe_arbiter_4: per-cycle model compare plus
// directed literal checks. Define PE_ARB_TIMEOUT_EN for the hold-limit tests.
module tb_pe_arbiter_4;

    localparam int HOLD_MAX = 4;
`ifdef PE_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic       rr_mode;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int n_chk  = 0;
    int n_fail = 0;

    pe_arbiter_4 #(
        .HOLD_MAX (HOLD_MAX),
        .CNT_W    (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .rr_mode   (rr_mode),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: owner index (-1 none), gap flag, rr pointer, grant-cycle count.
    int m_owner;
    int m_ptr;
    int m_cyc;
    bit m_gap;
    bit m_to;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner <= -1;
            m_ptr   <= 0;
            m_cyc   <= 0;
            m_gap   <= 1'b0;
            m_to    <= 1'b0;
        end else begin : step
            int  w;
            bit  lim;
            bit  rel;
            w    = -1;
            m_to <= 1'b0;
            if (m_owner >= 0) begin
                lim = TO_EN && (m_cyc == HOLD_MAX);
                rel = done || !req[m_owner] || lim;
                if (rel) begin
                    m_to    <= lim && !done && req[m_owner];
                    m_ptr   <= (m_owner + 1) % 4;
                    m_owner <= -1;
                    m_gap   <= 1'b1;
                end else begin
                    m_cyc <= m_cyc + 1;
                end
            end else if (m_gap) begin
                m_gap <= 1'b0;
            end else if (req != 4'b0000) begin
                if (rr_mode) begin
                    for (int k = 3; k >= 0; k--)
                        if (req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
                end else begin
                    for (int k = 0; k < 4; k++)
                        if (req[k]) w = k;
                end
                m_owner <= w;
                m_cyc   <= 1;
            end
        end
    end

    always @(negedge clk) begin
        int eg;
        eg = (m_owner >= 0) ? (1 << m_owner) : 0;
        chk("cyc_gnt", gnt, eg);
        chk("cyc_valid", gnt_valid, (m_owner >= 0) ? 1 : 0);
        chk("cyc_timeout", timeout, m_to);
        if (m_owner >= 0) chk("cyc_gnt_id", gnt_id, m_owner);
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(input string name);
        for (int k = 0; k < 10 && !gnt_valid; k++) cyc();
        chk(name, gnt_valid, 1);
    endtask

    initial begin
        rst_n   = 1'b0;
        req     = 4'b1111;
        done    = 1'b0;
        rr_mode = 1'b0;
        #3;
        chk("rst_gnt", gnt, 0);
        chk("rst_valid", gnt_valid, 0);
        chk("rst_id", gnt_id, 0);
        chk("rst_to", timeout, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        cyc();
        chk("first_gnt", gnt, 4'b1000);
        chk("first_id", gnt_id, 3);
        chk("first_valid", gnt_valid, 1);
        req = 4'b0000;
        repeat (3) cyc();

        // Fixed priority, done on grant cycle 3.
        req = 4'b0110;
        cyc();
        chk("fx_c1", gnt, 4'b0100);
        cyc();
        chk("fx_c2", gnt, 4'b0100);
        cyc();
        chk("fx_c3", gnt, 4'b0100);
        done = 1'b1;
        cyc();
        done = 1'b0;
        req  = 4'b0010;
        chk("fx_gap", gnt, 0);
        chk("fx_gap_v", gnt_valid, 0);
        cyc();
        chk("fx_idle", gnt, 0);
        cyc();
        chk("fx_next", gnt, 4'b0010);
        chk("fx_next_id", gnt_id, 1);
        req = 4'b0000;
        repeat (3) cyc();

        // Round-robin from reset: 0,1,2,3,0.
        rst_n   = 1'b0;
        rr_mode = 1'b1;
        req     = 4'b1111;
        cyc();
        rst_n = 1'b1;
        for (int n = 0; n < 5; n++) begin
            wait_valid("rr_wait");
            chk("rr_id", gnt_id, n % 4);
            if (n < 4) begin
                cyc();
                done = 1'b1;
                cyc();
                done = 1'b0;
                chk("rr_gap", gnt_valid, 0);
            end
        end

        // Reset mid-grant drops the grant immediately.
        rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt", gnt, 0);
        chk("mid_rst_v", gnt_valid, 0);
        rr_mode = 1'b0;
        req     = 4'b0000;
        cyc();
        rst_n = 1'b1;
        cyc();

        // No preemption; owner drop releases.
        req = 4'b0100;
        cyc();
        chk("np_c1", gnt, 4'b0100);
        req = 4'b1100;
        cyc();
        chk("np_c2", gnt, 4'b0100);
        cyc();
        chk("np_c3", gnt, 4'b0100);
        req = 4'b1000;
        cyc();
        chk("np_gap", gnt, 0);
        cyc();
        chk("np_idle", gnt, 0);
        cyc();
        chk("np_next", gnt, 4'b1000);
        chk("np_next_id", gnt_id, 3);
        req = 4'b0000;
        repeat (3) cyc();

        req = 4'b0001;
`ifdef PE_ARB_TIMEOUT_EN
        // Forced release after HOLD_MAX cycles.
        for (int c = 0; c < 4; c++) begin
            cyc();
            chk("to_hold", gnt, 4'b0001);
            chk("to_quiet", timeout, 0);
        end
        cyc();
        chk("to_gap", gnt, 0);
        chk("to_pulse", timeout, 1);
        cyc();
        chk("to_idle", timeout, 0);
        cyc();
        chk("to_regrant", gnt, 4'b0001);
        // done coincides with limit: single release, no timeout.
        cyc();
        cyc();
        cyc();
        chk("dl_c4", gnt, 4'b0001);
        done = 1'b1;
        cyc();
        done = 1'b0;
        chk("dl_gap", gnt, 0);
        chk("dl_no_to", timeout, 0);
        cyc();
        chk("dl_idle", timeout, 0);
`else
        for (int c = 0; c < 8; c++) begin
            cyc();
            chk("nt_hold", gnt, 4'b0001);
            chk("nt_quiet", timeout, 0);
        end
`endif
        req = 4'b0000;
        repeat (4) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
